// File: rtl/lcd1602_sequencer.sv
// -----------------------------------------------------------------------------
// lcd1602_sequencer
//
// Command sequencer in front of the 4-bit LCD 1602A nibble driver. Out of reset
// it waits T_PWRUP cycles, then issues the HD44780 init bytes
// 0x33, 0x32, 0x28, 0x0C, 0x01, 0x06 (all instructions). Each byte is followed
// by the settle delay that byte requires. After the last init byte it accepts
// one user byte at a time. All inter-command delay timing lives here. The
// driver only does the E/RS/RW strobing within a byte.
//
// User handshake (valid/ready): a byte transfers on a rising clk edge where
// i_wr_valid and o_wr_ready are both high. o_wr_ready is a pure function of the
// state (high only in IDLE) and never depends on i_wr_valid. i_wr_valid while
// o_wr_ready is low is ignored, not queued. The accepted byte appears on
// o_drv_data with o_drv_start exactly one cycle later.
//
// Driver handshake: o_drv_start is a one-cycle pulse. o_drv_data and
// o_drv_is_data are already valid in that cycle and stay stable until the
// driver completes. Completion is i_drv_rdy going low (accepted) and then high
// again (done). If that takes T_DRV_TO cycles from the start pulse, the block
// parks in ERR until rst.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous, active-high reset
//   i_wr_valid     in   user byte valid
//   i_wr_data      in   [7:0] user byte
//   i_wr_is_data   in   1: character (RS=1), 0: instruction (RS=0)
//   o_wr_ready     out  sequencer can accept a byte this cycle
//   o_init_done    out  init sequence complete (sticky until rst)
//   o_error        out  driver handshake timeout (sticky until rst)
//   o_drv_start    out  single-cycle start pulse to driver
//   o_drv_data     out  [7:0] byte to driver
//   o_drv_is_data  out  RS value to driver
//   i_drv_rdy      in   driver idle/ready
//   o_dbg_state    out  [2:0] current FSM state, for observation only
// -----------------------------------------------------------------------------
module lcd1602_sequencer #(
    parameter int unsigned T_PWRUP  = 300000,
    parameter int unsigned T_LONG   = 82000,
    parameter int unsigned T_MED    = 2000,
    parameter int unsigned T_CLEAR  = 32800,
    parameter int unsigned T_SHORT  = 840,
    parameter int unsigned T_DRV_TO = 4096,
    parameter int unsigned CNT_W    = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_valid,
    input  logic [7:0] i_wr_data,
    input  logic       i_wr_is_data,
    output logic       o_wr_ready,
    output logic       o_init_done,
    output logic       o_error,
    output logic       o_drv_start,
    output logic [7:0] o_drv_data,
    output logic       o_drv_is_data,
    input  logic       i_drv_rdy,
    output logic [2:0] o_dbg_state
);

    localparam int unsigned TO_W = $clog2(T_DRV_TO) + 1;

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(T_DRV_TO - 1);
    localparam logic [CNT_W-1:0] D_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] D_LONG  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] D_MED   = CNT_W'(T_MED - 1);
    localparam logic [CNT_W-1:0] D_CLEAR = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] D_SHORT = CNT_W'(T_SHORT - 1);

    typedef enum logic [2:0] {
        S_PWRUP   = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_DELAY   = 3'd4,
        S_IDLE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to;
    logic [2:0]       r_idx;
    logic [7:0]       r_drv_data;
    logic             r_drv_is_data;
    logic             r_init_done;

    logic             w_load;
    logic [7:0]       w_load_data;
    logic             w_load_is_data;
    logic             w_idx_inc;
    logic             w_set_done;
    logic             w_to_hit;
    logic             w_in_drv;
    logic [CNT_W-1:0] w_delay_val;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h33;
            3'd1:    init_byte = 8'h32;
            3'd2:    init_byte = 8'h28;
            3'd3:    init_byte = 8'h0C;
            3'd4:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    // The timeout counter is zero in every state outside the driver
    // handshake. It therefore reads 0 in the ISSUE cycle and counts cycles
    // since the start pulse.
    assign w_in_drv = (r_state == S_ISSUE) || (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
    assign w_to_hit = (r_to == TO_LAST);

    // The delay class uses the captured RS bit. A character 0x01 is an
    // ordinary write, not a clear.
    always_comb begin
        w_delay_val = D_SHORT;
        if (!r_drv_is_data) begin
            if (r_drv_data == 8'h33) begin
                w_delay_val = D_LONG;
            end else if (r_drv_data == 8'h32) begin
                w_delay_val = D_MED;
            end else if (r_drv_data >= 8'h01 && r_drv_data <= 8'h03) begin
                w_delay_val = D_CLEAR;
            end
        end
    end

    // The next-state logic also selects what gets loaded into the driver
    // byte register. That byte is on the outputs during the ISSUE cycle.
    always_comb begin
        w_next         = r_state;
        w_load         = 1'b0;
        w_load_data    = 8'h00;
        w_load_is_data = 1'b0;
        w_idx_inc      = 1'b0;
        w_set_done     = 1'b0;
        case (r_state)
            S_PWRUP: begin
                if (r_cnt == '0) begin
                    w_next      = S_ISSUE;
                    w_load      = 1'b1;
                    w_load_data = init_byte(r_idx);
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!i_drv_rdy) begin
                    w_next = S_WAIT_HI;
                end else if (w_to_hit) begin
                    w_next = S_ERR;
                end
            end
            S_WAIT_HI: begin
                if (i_drv_rdy) begin
                    w_next = S_DELAY;
                end else if (w_to_hit) begin
                    w_next = S_ERR;
                end
            end
            S_DELAY: begin
                if (r_cnt == '0) begin
                    if (r_init_done) begin
                        w_next = S_IDLE;
                    end else if (r_idx == 3'd5) begin
                        w_next     = S_IDLE;
                        w_set_done = 1'b1;
                    end else begin
                        w_next      = S_ISSUE;
                        w_idx_inc   = 1'b1;
                        w_load      = 1'b1;
                        w_load_data = init_byte(r_idx + 3'd1);
                    end
                end
            end
            S_IDLE: begin
                if (i_wr_valid) begin
                    w_next         = S_ISSUE;
                    w_load         = 1'b1;
                    w_load_data    = i_wr_data;
                    w_load_is_data = i_wr_is_data;
                end
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_PWRUP;
            r_cnt         <= D_PWRUP;
            r_to          <= '0;
            r_idx         <= 3'd0;
            r_drv_data    <= 8'h00;
            r_drv_is_data <= 1'b0;
            r_init_done   <= 1'b0;
        end else begin
            r_state <= w_next;

            // Shared countdown for power-up and post-byte delays. It saturates at 0.
            if (r_state == S_WAIT_HI && i_drv_rdy) begin
                r_cnt <= w_delay_val;
            end else if ((r_state == S_PWRUP || r_state == S_DELAY) && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_in_drv) begin
                if (!w_to_hit) begin
                    r_to <= r_to + TO_W'(1);
                end
            end else begin
                r_to <= '0;
            end

            if (w_load) begin
                r_drv_data    <= w_load_data;
                r_drv_is_data <= w_load_is_data;
            end

            if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_set_done) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign o_wr_ready    = (r_state == S_IDLE);
    assign o_drv_start   = (r_state == S_ISSUE);
    assign o_error       = (r_state == S_ERR);
    assign o_init_done   = r_init_done;
    assign o_drv_data    = r_drv_data;
    assign o_drv_is_data = r_drv_is_data;
    assign o_dbg_state   = r_state;

endmodule
